// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator: one shared edge- or center-aligned counter
// feeding CHANNELS compare outputs, with shadowed configuration applied at update events.
module pwm_multi_channel #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                      Clk50M,
  input  logic                      Rst,
  input  logic                      cnt_en,
  input  logic                      cfg_wr,
  input  logic [WIDTH-1:0]          cfg_arr,
  input  logic [CHANNELS*WIDTH-1:0] cfg_ccr,
  input  logic [CHANNELS-1:0]       cfg_pol,
  input  logic                      cfg_center,
  output logic                      cfg_busy,
  output logic                      period_end,
  output logic [CHANNELS-1:0]       o_pwm
);

  logic [WIDTH-1:0]          r_cnt;
  logic                      r_dirDown;
  logic [WIDTH-1:0]          r_arr;
  logic [CHANNELS*WIDTH-1:0] r_ccr;
  logic [CHANNELS-1:0]       r_pol;
  logic                      r_center;
  logic [WIDTH-1:0]          r_pArr;
  logic [CHANNELS*WIDTH-1:0] r_pCcr;
  logic [CHANNELS-1:0]       r_pPol;
  logic                      r_pCenter;
  logic                      r_busy;
  logic                      r_periodEnd;
  logic [CHANNELS-1:0]       r_pwm;

  logic                      w_upd;
  logic [WIDTH-1:0]          w_nextArr;
  logic                      w_nextCenter;
  logic [WIDTH-1:0]          w_cntInc;
  logic [WIDTH-1:0]          w_cntNext;
  logic                      w_dirNext;
  logic [CHANNELS-1:0]       w_cmp;

  // The reload after an update event must use the configuration being applied at that edge.
  always_comb begin
    w_nextArr    = r_busy ? r_pArr : r_arr;
    w_nextCenter = r_busy ? r_pCenter : r_center;
    w_cntInc     = r_cnt + WIDTH'(1);

    if (!cnt_en)
      w_upd = 1'b1;
    else if (!r_center)
      w_upd = (r_cnt == '0);
    else
      w_upd = (r_arr == '0) || (r_dirDown && (r_cnt <= WIDTH'(1)));

    w_cntNext = r_cnt;
    w_dirNext = r_dirDown;
    if (w_upd) begin
      w_cntNext = w_nextCenter ? '0 : w_nextArr;
      w_dirNext = 1'b0;
    end else if (!r_center || r_dirDown) begin
      w_cntNext = r_cnt - WIDTH'(1);
    end else begin
      w_cntNext = w_cntInc;
      w_dirNext = (w_cntInc >= r_arr);
    end

    w_cmp = '0;
    for (int k = 0; k < CHANNELS; k++)
      w_cmp[k] = (r_cnt >= r_ccr[k*WIDTH +: WIDTH]) ^ r_pol[k];
  end

  always_ff @(posedge Clk50M) begin
    if (Rst) begin
      r_cnt       <= '0;
      r_dirDown   <= 1'b0;
      r_arr       <= '0;
      r_ccr       <= '0;
      r_pol       <= '0;
      r_center    <= 1'b0;
      r_pArr      <= '0;
      r_pCcr      <= '0;
      r_pPol      <= '0;
      r_pCenter   <= 1'b0;
      r_busy      <= 1'b0;
      r_periodEnd <= 1'b0;
      r_pwm       <= '1;
    end else begin
      r_cnt       <= w_cntNext;
      r_dirDown   <= w_dirNext;
      r_periodEnd <= w_upd && cnt_en;
      r_pwm       <= w_cmp;

      if (w_upd && r_busy) begin
        r_arr    <= r_pArr;
        r_ccr    <= r_pCcr;
        r_pol    <= r_pPol;
        r_center <= r_pCenter;
      end

      // A write coinciding with an update lands in the shadow after the old shadow is applied.
      if (cfg_wr) begin
        r_pArr    <= cfg_arr;
        r_pCcr    <= cfg_ccr;
        r_pPol    <= cfg_pol;
        r_pCenter <= cfg_center;
        r_busy    <= 1'b1;
      end else if (w_upd) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign cfg_busy   = r_busy;
  assign period_end = r_periodEnd;
  assign o_pwm      = r_pwm;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed bench for pwm_multi_channel at WIDTH=8, CHANNELS=2 with
// hand-computed per-cycle expectations for o_pwm, period_end and cfg_busy.
module tb_pwm_multi_channel;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;

  logic                      Clk50M;
  logic                      Rst;
  logic                      cntEn;
  logic                      cfgWr;
  logic [WIDTH-1:0]          cfgArr;
  logic [CHANNELS*WIDTH-1:0] cfgCcr;
  logic [CHANNELS-1:0]       cfgPol;
  logic                      cfgCenter;
  logic                      cfgBusy;
  logic                      periodEnd;
  logic [CHANNELS-1:0]       pwm;

  int checks = 0;
  int errors = 0;

  pwm_multi_channel #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .Clk50M     (Clk50M),
    .Rst        (Rst),
    .cnt_en     (cntEn),
    .cfg_wr     (cfgWr),
    .cfg_arr    (cfgArr),
    .cfg_ccr    (cfgCcr),
    .cfg_pol    (cfgPol),
    .cfg_center (cfgCenter),
    .cfg_busy   (cfgBusy),
    .period_end (periodEnd),
    .o_pwm      (pwm)
  );

  initial Clk50M = 1'b0;
  always #10 Clk50M = ~Clk50M;

  task automatic tick();
    @(posedge Clk50M);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle cfg_wr strobe carrying a full configuration
  task automatic applyStimulus(input logic [7:0] arr, input logic [7:0] ccr0, input logic [7:0] ccr1,
                               input logic [1:0] pol, input logic center);
    cfgArr    = arr;
    cfgCcr    = {ccr1, ccr0};
    cfgPol    = pol;
    cfgCenter = center;
    cfgWr     = 1'b1;
    tick();
    cfgWr     = 1'b0;
  endtask

  // Bit i of ch0Pat / pePat gives the expected value after the i-th edge
  task automatic runCycles(input string tag, input int n, input logic [31:0] ch0Pat,
                           input logic ch1Exp, input logic [31:0] pePat);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput($sformatf("%s_pwm%0d", tag, i), {30'd0, pwm}, {30'd0, ch1Exp, ch0Pat[i]});
      checkOutput($sformatf("%s_pe%0d", tag, i), {31'd0, periodEnd}, {31'd0, pePat[i]});
    end
  endtask

  initial begin
    Rst = 1'b1; cntEn = 1'b0; cfgWr = 1'b0;
    cfgArr = '0; cfgCcr = '0; cfgPol = '0; cfgCenter = 1'b0;

    tick(); tick();
    checkOutput("rst_pwm",  {30'd0, pwm},       32'h3);
    checkOutput("rst_busy", {31'd0, cfgBusy},   32'h0);
    checkOutput("rst_pe",   {31'd0, periodEnd}, 32'h0);

    // Edge-aligned, arr=9, ch0 ccr=5, ch1 ccr=0
    Rst = 1'b0; cntEn = 1'b1;
    applyStimulus(8'd9, 8'd5, 8'd0, 2'b00, 1'b0);
    checkOutput("edge_busy_set", {31'd0, cfgBusy},   32'h1);
    checkOutput("edge_pe_first", {31'd0, periodEnd}, 32'h1);
    tick();
    checkOutput("edge_busy_clr", {31'd0, cfgBusy},   32'h0);
    checkOutput("edge_pe_apply", {31'd0, periodEnd}, 32'h1);
    runCycles("edge", 10, 32'h1F, 1'b1, 32'h200);

    // Shadow update with counter at 6
    runCycles("shA", 3, 32'h7, 1'b1, 32'h0);
    applyStimulus(8'd9, 8'd2, 8'd0, 2'b00, 1'b0);
    checkOutput("sh_busy_pend", {31'd0, cfgBusy}, 32'h1);
    runCycles("shB", 6, 32'h1, 1'b1, 32'h20);
    checkOutput("sh_busy_clr", {31'd0, cfgBusy}, 32'h0);
    runCycles("shC", 10, 32'hFF, 1'b1, 32'h200);

    // ccr above arr, then inverted polarity
    applyStimulus(8'd9, 8'd10, 8'd0, 2'b00, 1'b0);
    runCycles("big1", 9, 32'h7F, 1'b1, 32'h100);
    runCycles("big2", 10, 32'h0, 1'b1, 32'h200);
    applyStimulus(8'd9, 8'd10, 8'd0, 2'b01, 1'b0);
    runCycles("pol1", 9, 32'h0, 1'b1, 32'h100);
    runCycles("pol2", 10, 32'h3FF, 1'b1, 32'h200);

    // Center-aligned, arr=4, ch0 ccr=3
    applyStimulus(8'd4, 8'd3, 8'd0, 2'b00, 1'b1);
    checkOutput("ctr_busy_pend", {31'd0, cfgBusy}, 32'h1);
    runCycles("ctrA", 9, 32'h1FF, 1'b1, 32'h100);
    checkOutput("ctr_busy_clr", {31'd0, cfgBusy}, 32'h0);
    runCycles("ctrB", 16, 32'h3838, 1'b1, 32'h8080);

    // arr=0 in edge mode: period_end every cycle
    applyStimulus(8'd0, 8'd0, 8'd0, 2'b00, 1'b0);
    runCycles("arr0A", 7, 32'h1C, 1'b1, 32'h40);
    checkOutput("arr0_busy_clr", {31'd0, cfgBusy}, 32'h0);
    runCycles("arr0B", 8, 32'hFF, 1'b1, 32'hFF);

    // cfg_wr coinciding with an update event
    applyStimulus(8'd9, 8'd5, 8'd0, 2'b00, 1'b0);
    checkOutput("sim1_busy", {31'd0, cfgBusy},   32'h1);
    checkOutput("sim1_pe",   {31'd0, periodEnd}, 32'h1);
    runCycles("sim1", 1, 32'h1, 1'b1, 32'h1);
    checkOutput("sim1_busy_clr", {31'd0, cfgBusy}, 32'h0);
    runCycles("sim2", 10, 32'h1F, 1'b1, 32'h200);
    runCycles("sim3", 9, 32'h1F, 1'b1, 32'h0);
    applyStimulus(8'd9, 8'd2, 8'd0, 2'b00, 1'b0);
    checkOutput("sim4_busy", {31'd0, cfgBusy}, 32'h1);
    runCycles("sim4", 9, 32'h1F, 1'b1, 32'h0);
    checkOutput("sim4_busy_held", {31'd0, cfgBusy}, 32'h1);
    runCycles("sim5", 1, 32'h0, 1'b1, 32'h1);
    checkOutput("sim5_busy_clr", {31'd0, cfgBusy}, 32'h0);
    runCycles("sim6", 10, 32'hFF, 1'b1, 32'h200);

    // Enable drop with pending arr=3
    runCycles("enA", 3, 32'h7, 1'b1, 32'h0);
    applyStimulus(8'd3, 8'd2, 8'd0, 2'b00, 1'b0);
    checkOutput("en_busy_pend", {31'd0, cfgBusy}, 32'h1);
    cntEn = 1'b0;
    runCycles("enIdle1", 1, 32'h1, 1'b1, 32'h0);
    checkOutput("en_busy_clr", {31'd0, cfgBusy}, 32'h0);
    runCycles("enIdle2", 1, 32'h1, 1'b1, 32'h0);
    cntEn = 1'b1;
    runCycles("enRun", 8, 32'h33, 1'b1, 32'h88);

    // Reset while a configuration is pending
    applyStimulus(8'd7, 8'd1, 8'd1, 2'b00, 1'b0);
    checkOutput("rst2_busy_pend", {31'd0, cfgBusy}, 32'h1);
    Rst = 1'b1;
    tick();
    checkOutput("rst2_busy", {31'd0, cfgBusy},   32'h0);
    checkOutput("rst2_pwm",  {30'd0, pwm},       32'h3);
    checkOutput("rst2_pe",   {31'd0, periodEnd}, 32'h0);
    Rst = 1'b0;
    runCycles("rst2run", 3, 32'h7, 1'b1, 32'h7);
    checkOutput("rst2_busy_after", {31'd0, cfgBusy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
